// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last grant.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int   w_idx;
  logic w_found;

  // Walk the requesters in rotated order and keep the first one asserted.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = (int'(last_grant) + off) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory handshake port between NUM_REQ
// requesters; one transfer in flight, with a timeout on a silent memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic                         rsp_err,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         mem_valid,
  output logic                         mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ready,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value during the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] w_pick;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_grant_onehot;
  logic               w_accept;
  logic               w_timeout;

  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  // Unpack the flat requester buses into per-requester fields.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .gnt        (w_pick),
    .gnt_idx    (w_pick_idx)
  );

  assign w_grant_onehot = NUM_REQ'(1) << r_grant;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ISSUE;
      ISSUE:   if (mem_ready || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Combinational accept strobe and timeout detect.
  always_comb begin
    req_ready = '0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    if (r_state == IDLE) begin
      req_ready = w_pick;
      w_accept  = |(req_valid & w_pick);
    end
    if (r_state == ISSUE && !mem_ready && r_cnt >= CNT_LAST) begin
      w_timeout = 1'b1;
    end
  end

  // Latched request fields, timeout counter and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_cnt        <= '0;
      mem_valid    <= 1'b0;
      mem_wr_rd    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant   <= w_pick_idx;
            r_cnt     <= '0;
            mem_valid <= 1'b1;
            mem_wr_rd <= req_wr_rd[w_pick_idx];
            mem_addr  <= w_addr_arr[w_pick_idx];
            mem_wdata <= w_wdata_arr[w_pick_idx];
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            rsp_valid <= w_grant_onehot;
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_wr_rd ? '0 : mem_rdata;
          end else begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (w_timeout) begin
              mem_valid <= 1'b0;
              rsp_valid <= w_grant_onehot;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        RESP: begin
          rsp_valid    <= '0;
          rsp_err      <= 1'b0;
          rsp_rdata    <= '0;
          r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_wr_rd;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic              mem_valid;
  logic              mem_wr_rd;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;

  mem_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr_rd (req_wr_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_valid (mem_valid),
    .mem_wr_rd (mem_wr_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: mode 0 = ready always, 1 = never ready, 2 = ready on 4th valid cycle.
  logic [DW-1:0] mem [256];
  int mem_mode = 0;
  int wait_cnt = 0;
  assign mem_ready = (mem_mode == 0) ? 1'b1 : ((mem_mode == 2) && (wait_cnt == 3));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_valid && mem_ready && mem_wr_rd) mem[mem_addr] <= mem_wdata;
    if (!mem_valid || mem_ready) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  // Event counters for "never happened" checks.
  int rsp_cnt  = 0;
  int rsp2_cnt = 0;
  int gnt2_cnt = 0;
  always @(posedge clk) begin
    if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (rsp_valid[2]) rsp2_cnt <= rsp2_cnt + 1;
    if (req_valid[2] && req_ready[2]) gnt2_cnt <= gnt2_cnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_wr_rd[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Single transfer with memory ready on the first cycle; called at a negedge.
  task automatic xfer(input int i, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    set_req(i, wr, a, d);
    req_valid = NR'(1) << i;
    #1 chk("xf_ready", 32'(req_ready), 32'(NR'(1) << i));
    @(negedge clk);
    req_valid = '0;
    chk("xf_mem_valid", 32'(mem_valid), 32'd1);
    chk("xf_mem_addr", 32'(mem_addr), 32'(a));
    chk("xf_mem_wr_rd", 32'(mem_wr_rd), 32'(wr));
    @(negedge clk);
    chk("xf_rsp_valid", 32'(rsp_valid), 32'(NR'(1) << i));
    chk("xf_rsp_err", 32'(rsp_err), 32'd0);
    chk("xf_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    @(negedge clk);
    chk("xf_rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int vcnt;
    int snap;
    int snap2;
    int g2;
    req_valid = '0;
    req_wr_rd = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[5] = 16'h1234;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;

    // Write then read back through requester 0
    xfer(0, 1'b1, 8'h10, 16'hABCD, 16'h0000);
    xfer(0, 1'b0, 8'h10, 16'h0000, 16'hABCD);

    // Fairness: all four request from reset
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(i), 16'h0);
    req_valid = '1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("fair_gnt", 32'(req_ready), 32'(NR'(1) << (k % NR)));
      @(negedge clk);
      @(negedge clk);
      chk("fair_rsp", 32'(rsp_valid), 32'(NR'(1) << (k % NR)));
      @(negedge clk);
    end
    req_valid = '0;

    // Wait states: ready on the 4th valid cycle of a read of 0x05
    mem_mode = 2;
    set_req(0, 1'b0, 8'h05, 16'h0);
    req_valid = 4'b0001;
    #1 chk("ws_ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = '0;
      chk("ws_mem_valid", 32'(mem_valid), 32'd1);
      chk("ws_mem_addr", 32'(mem_addr), 32'h05);
      chk("ws_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("ws_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("ws_rsp_rdata", 32'(rsp_rdata), 32'h1234);
    chk("ws_rsp_err", 32'(rsp_err), 32'd0);
    chk("ws_mem_drop", 32'(mem_valid), 32'd0);
    @(negedge clk);

    // Timeout: memory never answers; requester 2 then 3 waiting
    mem_mode = 1;
    set_req(2, 1'b0, 8'h20, 16'h0);
    set_req(3, 1'b0, 8'h30, 16'h0);
    req_valid = 4'b1100;
    #1 chk("to_ready", 32'(req_ready), 32'h4);
    vcnt = 0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      if (mem_valid) vcnt++;
    end
    chk("to_valid_cycles", 32'(vcnt), 32'(TO));
    @(negedge clk);
    chk("to_mem_drop", 32'(mem_valid), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    chk("to_next_gnt", 32'(req_ready), 32'h8);
    req_valid = '0;

    // Reset in the middle of ISSUE
    snap = rsp_cnt;
    set_req(1, 1'b0, 8'h40, 16'h0);
    req_valid = 4'b0010;
    #1 chk("rm_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    chk("rm_mem_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    chk("rm_mem_valid2", 32'(mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rm_async_drop", 32'(mem_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rm_no_rsp", 32'(rsp_cnt - snap), 32'd0);
    mem_mode = 0;
    req_valid = '1;
    rst = 1'b0;
    #1 chk("rm_prio0", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);

    // Requester 2 pulses valid only while the arbiter is busy
    snap2 = rsp2_cnt;
    g2 = gnt2_cnt;
    set_req(0, 1'b1, 8'h50, 16'h5555);
    set_req(2, 1'b1, 8'h60, 16'h6666);
    req_valid = 4'b0001;
    #1 chk("wd_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0101;
    #1 chk("wd_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    chk("wd_rsp0", 32'(rsp_valid), 32'h1);
    @(negedge clk);
    chk("wd_idle_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("wd_no_gnt2", 32'(gnt2_cnt - g2), 32'd0);
    chk("wd_no_rsp2", 32'(rsp2_cnt - snap2), 32'd0);
    chk("wd_mem_write", 32'(mem[8'h50]), 32'h5555);
    chk("wd_mem_untouched", 32'(mem[8'h60]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port `memory` handshake interface (`addr`/`wdata`/`rdata`/`wr_rd`/`valid`/`ready`) between `NUM_REQ` requesters. It accepts one request at a time and drives it onto the memory port. It returns read data or a write completion to the granted requester, and aborts transfers the memory fails to acknowledge within `TIMEOUT` cycles. It sits between the requester agents and the `memory` instance, in place of a direct single-master connection.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `ADDR_WIDTH`, 8, memory address width
- `DATA_WIDTH`, 16, memory data width
- `TIMEOUT`, 16, max cycles `mem_valid` may wait for `mem_ready` (≥1)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req_valid`  in  NUM_REQ  per-requester request pending
- `req_wr_rd`  in  NUM_REQ  per-requester direction: 1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `req_ready`  out  NUM_REQ  one-hot accept; transfer when `req_valid[i] && req_ready[i]`
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `rsp_err`  out  1  qualifies `rsp_valid`: 1 = timed out
- `rsp_rdata`  out  DATA_WIDTH  read data; valid with `rsp_valid` for reads, 0 otherwise
- `mem_valid`  out  1  memory request valid
- `mem_wr_rd`  out  1  memory direction, 1 = write
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_ready`  in  1  memory accept/complete
- `mem_rdata`  in  DATA_WIDTH  memory read data; sampled on the `mem_valid && mem_ready` cycle

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Round-robin pick among asserted `req_valid`. Search starts at `last_grant+1` mod `NUM_REQ`.
  - `req_ready` is combinational: the one-hot of the pick, zero if no `req_valid` is set.
  - On accept, latch grant index, `wr_rd`, addr and wdata; clear the timeout counter; go to ISSUE.
- ISSUE:
  - `mem_valid`=1 with latched fields held stable.
  - On `mem_ready`: capture `mem_rdata` if read (0 if write), clear the error flag, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, drop `mem_valid`, set the error flag, capture rdata=0, go to RESP.
- RESP:
  - `rsp_valid[grant]`=1 for exactly one cycle, with `rsp_err`/`rsp_rdata` from the captured values.
  - `last_grant` ← grant; go to IDLE.
- `req_ready` is 0 in ISSUE and RESP. Requester inputs are ignored outside IDLE.
- Round-robin is work-conserving. With all `NUM_REQ` requesting continuously, each is served once per `NUM_REQ` grants.
- Timeout counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values (async, immediate):
  - State IDLE; `last_grant`=NUM_REQ-1, so requester 0 has first priority.
  - `mem_valid`=0, `mem_wr_rd`=0, `mem_addr`=0, `mem_wdata`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `req_ready` follows the IDLE pick once `rst` deasserts.
- Memory outputs and `rsp_*` are registered. `req_ready` is combinational from `req_valid` and `last_grant`.
- Latency with `mem_ready` high on first `mem_valid` cycle:
  - accept at cycle N, `mem_valid` at N+1, `rsp_valid` at N+2, next accept possible at N+3.
  - Minimum 3 cycles per transfer. Each wait cycle of `mem_ready` adds one.
- Timeout: `mem_valid` high for exactly `TIMEOUT` cycles without `mem_ready` → `rsp_valid` with `rsp_err`=1 the following cycle.
- `mem_ready` while `mem_valid`=0 is ignored.
- `rst` asserted mid-transfer: the transfer is abandoned and no `rsp_valid` is issued. The requester must re-request.

## Structure
- Package `mem_arb_pkg`: FSM state enum (IDLE/ISSUE/RESP) and default width constants (ADDR_WIDTH, DATA_WIDTH).
- Sub-module `rr_arbiter`: purely combinational. Inputs are `req[NUM_REQ]` and `last_grant`; outputs are `gnt` one-hot and `gnt_idx`. Instantiated once.

## Test plan
- Single write then read: req0 writes addr 0x10 data 0xABCD, then reads 0x10, with `mem_ready` tied high.
  - Expect each accept→`rsp_valid[0]` in 2 cycles.
  - Read returns `rsp_rdata`=0xABCD with `rsp_err`=0.
- Fairness: all four requesters hold `req_valid` from reset.
  - Grant order is 0,1,2,3,0,1… and each grant is 3 cycles apart.
- Wait states: `mem_ready` delayed 3 cycles on a read of 0x05.
  - `mem_valid`/`mem_addr` stay stable for 4 cycles.
  - `rsp_valid` arrives 1 cycle after `mem_ready` with the correct data.
- Timeout with `TIMEOUT`=16 and `mem_ready` held low.
  - `mem_valid` is high for exactly 16 cycles.
  - Then `rsp_valid[g]`=1, `rsp_err`=1, `rsp_rdata`=0, and the next requester is granted.
- Reset mid-ISSUE: assert `rst` while `mem_valid`=1.
  - `mem_valid` drops immediately and no `rsp_valid` is issued.
  - After release, requester 0 has priority.
- Request withdrawn: requester 2 pulses `req_valid` for 1 cycle while the arbiter is in ISSUE.
  - Requester 2 is never granted and gets no `rsp_valid[2]`.
